// File: rtl/memory_game_ctrl_if.sv
// Board-side bundle for the memory-game turn sequencer.
// The master side supplies frame, player and deck inputs. The slave side (the controller) returns the card state.
interface memory_game_ctrl_if;
  logic        frame_tick;
  logic        select;
  logic [3:0]  cursor;
  logic [47:0] deck;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [3:0]  first_pos;
  logic [7:0]  moves;
  logic [3:0]  pairs_found;
  logic        busy;
  logic        game_over;

  modport master (
    output frame_tick, select, cursor, deck,
    input  face_up, matched, first_pos, moves, pairs_found, busy, game_over
  );

  modport slave (
    input  frame_tick, select, cursor, deck,
    output face_up, matched, first_pos, moves, pairs_found, busy, game_over
  );
endinterface

// File: rtl/memory_game_ctrl.sv
// Turn sequencer for the 4x4 memory-card board.
// It handles flip, compare, mismatch hold and the match bookkeeping that drives the renderers and score.
module memory_game_ctrl #(
  parameter int HOLD_FRAMES = 60,
  parameter int NUM_PAIRS   = 8
) (
  input  logic              clk,
  input  logic              reset,
  memory_game_ctrl_if.slave bus
);
  localparam int          CARDS     = 2 * NUM_PAIRS;
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [3:0]  PAIRS_ALL = 4'(NUM_PAIRS);

  typedef enum logic [2:0] {IDLE, ONE, CMP, HOLD, DONE} state_t;

  state_t            state, state_n;
  logic [CARDS-1:0]  face_up, face_up_n;
  logic [CARDS-1:0]  matched, matched_n;
  logic [3:0]        first_pos, first_pos_n;
  logic [3:0]        second_pos, second_pos_n;
  logic [7:0]        moves, moves_n;
  logic [3:0]        pairs_found, pairs_found_n;
  logic [7:0]        hold_cnt, hold_cnt_n;
  logic              valid_sel;

  // Per-position pair ID, so the compare indexes with the exact 4-bit position.
  logic [2:0] ids [CARDS];
  for (genvar i = 0; i < CARDS; i++) begin : g_id
    assign ids[i] = bus.deck[3*i +: 3];
  end

  assign valid_sel = bus.select && !face_up[bus.cursor];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      face_up     <= '0;
      matched     <= '0;
      first_pos   <= '0;
      second_pos  <= '0;
      moves       <= '0;
      pairs_found <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_n;
      face_up     <= face_up_n;
      matched     <= matched_n;
      first_pos   <= first_pos_n;
      second_pos  <= second_pos_n;
      moves       <= moves_n;
      pairs_found <= pairs_found_n;
      hold_cnt    <= hold_cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    face_up_n     = face_up;
    matched_n     = matched;
    first_pos_n   = first_pos;
    second_pos_n  = second_pos;
    moves_n       = moves;
    pairs_found_n = pairs_found;
    hold_cnt_n    = hold_cnt;
    case (state)
      IDLE: if (valid_sel) begin
        face_up_n[bus.cursor] = 1'b1;
        first_pos_n           = bus.cursor;
        state_n               = ONE;
      end
      ONE: if (valid_sel) begin
        face_up_n[bus.cursor] = 1'b1;
        second_pos_n          = bus.cursor;
        state_n               = CMP;
      end
      CMP: begin
        moves_n = (moves == 8'hFF) ? moves : moves + 8'd1;
        if (ids[first_pos] == ids[second_pos]) begin
          matched_n[first_pos]  = 1'b1;
          matched_n[second_pos] = 1'b1;
          pairs_found_n         = pairs_found + 4'd1;
          state_n               = (pairs_found + 4'd1 == PAIRS_ALL) ? DONE : IDLE;
        end else begin
          hold_cnt_n = '0;
          state_n    = HOLD;
        end
      end
      HOLD: if (bus.frame_tick) begin
        if (hold_cnt == HOLD_LAST) begin
          face_up_n[first_pos]  = 1'b0;
          face_up_n[second_pos] = 1'b0;
          hold_cnt_n            = '0;
          state_n               = IDLE;
        end else begin
          hold_cnt_n = hold_cnt + 8'd1;
        end
      end
      DONE: ;
      default: state_n = IDLE;
    endcase
  end

  assign bus.face_up     = face_up;
  assign bus.matched     = matched;
  assign bus.first_pos   = first_pos;
  assign bus.moves       = moves;
  assign bus.pairs_found = pairs_found;
  assign bus.busy        = (state == CMP) || (state == HOLD);
  assign bus.game_over   = (state == DONE);
endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed vector table plus a full-game sequence for memory_game_ctrl, using HOLD_FRAMES=3.
module tb_memory_game_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_game_ctrl_if bus ();
  memory_game_ctrl #(.HOLD_FRAMES(3), .NUM_PAIRS(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst, sel, ft;
    logic [3:0]  cur;
    logic [15:0] face, mat;
    logic [3:0]  fp;
    logic [7:0]  mv;
    logic [3:0]  pf;
    logic        busy, go;
  } vec_t;

  vec_t vt [25];
  int   idv [16] = '{3,3,1,0,2,0,2,4,5,6,7,4,5,6,7,1};
  int   ta  [10] = '{0,2,2,3,4,4,7,8,9,10};
  int   tb  [10] = '{1,3,15,5,7,6,11,12,13,14};

  function automatic vec_t mk(logic rst, logic sel, logic ft, logic [3:0] cur,
                              logic [15:0] face, logic [15:0] mat, logic [3:0] fp,
                              logic [7:0] mv, logic [3:0] pf, logic busy, logic go);
    vec_t v;
    v.rst = rst; v.sel = sel; v.ft = ft; v.cur = cur; v.face = face; v.mat = mat;
    v.fp = fp; v.mv = mv; v.pf = pf; v.busy = busy; v.go = go;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic sel, input logic ft, input logic [3:0] cur);
    @(negedge clk);
    reset = rst; bus.select = sel; bus.frame_tick = ft; bus.cursor = cur;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_mat;
    logic [7:0]  exp_mv;
    logic [3:0]  exp_pf;
    reset = 1'b1; bus.select = 1'b0; bus.frame_tick = 1'b0; bus.cursor = '0;
    for (int i = 0; i < 16; i++) bus.deck[3*i +: 3] = 3'(idv[i]);

    //           rst sel ft cur  face      mat       fp mv pf busy go
    vt[0]  = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 1, 0, 5, 16'h0020, 16'h0000, 5, 0, 0, 0, 0);
    vt[3]  = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 1, 0, 0, 16'h0001, 16'h0000, 0, 0, 0, 0, 0);
    vt[5]  = mk(0, 1, 0, 0, 16'h0001, 16'h0000, 0, 0, 0, 0, 0); // reselect face-up card in ONE
    vt[6]  = mk(0, 1, 0, 1, 16'h0003, 16'h0000, 0, 0, 0, 1, 0);
    vt[7]  = mk(0, 0, 0, 0, 16'h0003, 16'h0003, 0, 1, 1, 0, 0);
    vt[8]  = mk(0, 1, 0, 1, 16'h0003, 16'h0003, 0, 1, 1, 0, 0); // matched card ignored
    vt[9]  = mk(0, 1, 0, 2, 16'h0007, 16'h0003, 2, 1, 1, 0, 0);
    vt[10] = mk(0, 1, 0, 2, 16'h0007, 16'h0003, 2, 1, 1, 0, 0);
    vt[11] = mk(0, 1, 0, 7, 16'h0087, 16'h0003, 2, 1, 1, 1, 0);
    vt[12] = mk(0, 0, 0, 0, 16'h0087, 16'h0003, 2, 2, 1, 1, 0);
    vt[13] = mk(0, 0, 1, 0, 16'h0087, 16'h0003, 2, 2, 1, 1, 0);
    vt[14] = mk(0, 1, 0, 9, 16'h0087, 16'h0003, 2, 2, 1, 1, 0); // select during HOLD
    vt[15] = mk(0, 0, 1, 0, 16'h0087, 16'h0003, 2, 2, 1, 1, 0);
    vt[16] = mk(0, 0, 1, 0, 16'h0003, 16'h0003, 2, 2, 1, 0, 0);
    vt[17] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    vt[18] = mk(0, 1, 0, 2, 16'h0004, 16'h0000, 2, 0, 0, 0, 0);
    vt[19] = mk(0, 1, 0, 7, 16'h0084, 16'h0000, 2, 0, 0, 1, 0);
    vt[20] = mk(0, 0, 0, 0, 16'h0084, 16'h0000, 2, 1, 0, 1, 0);
    vt[21] = mk(0, 0, 1, 0, 16'h0084, 16'h0000, 2, 1, 0, 1, 0);
    vt[22] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0); // reset mid-HOLD
    vt[23] = mk(0, 1, 0, 5, 16'h0020, 16'h0000, 5, 0, 0, 0, 0);
    vt[24] = mk(1, 1, 0, 3, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      step(vt[i].rst, vt[i].sel, vt[i].ft, vt[i].cur);
      chk($sformatf("v%0d_face", i), 32'(bus.face_up), 32'(vt[i].face));
      chk($sformatf("v%0d_mat", i), 32'(bus.matched), 32'(vt[i].mat));
      chk($sformatf("v%0d_fp", i), 32'(bus.first_pos), 32'(vt[i].fp));
      chk($sformatf("v%0d_moves", i), 32'(bus.moves), 32'(vt[i].mv));
      chk($sformatf("v%0d_pairs", i), 32'(bus.pairs_found), 32'(vt[i].pf));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vt[i].busy));
      chk($sformatf("v%0d_over", i), 32'(bus.game_over), 32'(vt[i].go));
    end

    // Full game from a freshly reset board: eight matches and two misses.
    exp_mat = '0; exp_mv = '0; exp_pf = '0;
    for (int t = 0; t < 10; t++) begin
      step(0, 1, 0, 4'(ta[t]));
      step(0, 1, 0, 4'(tb[t]));
      chk($sformatf("g%0d_cmp_busy", t), 32'(bus.busy), 32'd1);
      step(0, 0, 0, 0);
      exp_mv++;
      if (idv[ta[t]] == idv[tb[t]]) begin
        exp_mat = exp_mat | (16'd1 << ta[t]) | (16'd1 << tb[t]);
        exp_pf++;
        chk($sformatf("g%0d_busy", t), 32'(bus.busy), 32'd0);
      end else begin
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk($sformatf("g%0d_hold_busy", t), 32'(bus.busy), 32'd1);
        step(0, 0, 1, 0);
        chk($sformatf("g%0d_release", t), 32'(bus.busy), 32'd0);
      end
      chk($sformatf("g%0d_moves", t), 32'(bus.moves), 32'(exp_mv));
      chk($sformatf("g%0d_pairs", t), 32'(bus.pairs_found), 32'(exp_pf));
      chk($sformatf("g%0d_mat", t), 32'(bus.matched), 32'(exp_mat));
      chk($sformatf("g%0d_face", t), 32'(bus.face_up), 32'(exp_mat));
      chk($sformatf("g%0d_over", t), 32'(bus.game_over), 32'(exp_pf == 4'd8));
    end
    chk("final_mat", 32'(bus.matched), 32'hFFFF);
    chk("final_moves", 32'(bus.moves), 32'd10);
    step(0, 1, 1, 0);
    step(0, 1, 0, 9);
    chk("done_moves", 32'(bus.moves), 32'd10);
    chk("done_over", 32'(bus.game_over), 32'd1);
    chk("done_pairs", 32'(bus.pairs_found), 32'd8);
    step(1, 0, 0, 0);
    chk("done_reset_over", 32'(bus.game_over), 32'd0);
    chk("done_reset_face", 32'(bus.face_up), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
